// File: rtl/fq_pkg.sv
// Fetch-queue shared definitions: default depth, reset fetch address, entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Optional FQ_ALIGN_CHECK_EN adds the adel entry field.
package fq_pkg;

   localparam int          FQ_DEPTH_DEF  = 4;
   localparam logic [31:0] FQ_RESET_ADDR = 32'h0000_3000;

   // Entry layout (LSB first): pc, instr, then optional adel flag.
   localparam int FQ_PC_W      = 32;
   localparam int FQ_PC_LSB    = 0;
   localparam int FQ_INSTR_W   = 32;
   localparam int FQ_INSTR_LSB = FQ_PC_LSB + FQ_PC_W;

`ifdef FQ_ALIGN_CHECK_EN
   localparam int FQ_ADEL_W    = 1;
   localparam int FQ_ADEL_LSB  = FQ_INSTR_LSB + FQ_INSTR_W;
   localparam int FQ_ENTRY_W   = FQ_ADEL_LSB + FQ_ADEL_W;

   typedef struct packed {
      logic                  adel;
      logic [FQ_INSTR_W-1:0] instr;
      logic [FQ_PC_W-1:0]    pc;
   } fq_entry_t;

   // A fetch address is misaligned when it is not word aligned.
   function automatic logic fq_misaligned(input logic [31:0] pc);
      return (pc[1:0] != 2'b00);
   endfunction
`else
   localparam int FQ_ENTRY_W   = FQ_INSTR_LSB + FQ_INSTR_W;

   typedef struct packed {
      logic [FQ_INSTR_W-1:0] instr;
      logic [FQ_PC_W-1:0]    pc;
   } fq_entry_t;
`endif

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-queue signal bundle: PC request, instruction-memory port, decode-side output.
// Latency: n/a (wiring only).
// Backpressure: pcValid/pcReady upstream, outValid/outReady downstream. fq_outAdel exists only with FQ_ALIGN_CHECK_EN.
interface fetch_queue_if;

   logic [31:0] fq_pcIn;
   logic        fq_pcValid;
   logic        fq_pcReady;
   logic [31:0] fq_imAddr;
   logic        fq_imRd;
   logic [31:0] fq_imData;
   logic        fq_flush;
   logic [31:0] fq_outPc;
   logic [31:0] fq_outInstr;
   logic        fq_outValid;
   logic        fq_outReady;
`ifdef FQ_ALIGN_CHECK_EN
   logic        fq_outAdel;
`endif

   // Queue side.
   modport master (
`ifdef FQ_ALIGN_CHECK_EN
      output fq_outAdel,
`endif
      input  fq_pcIn, fq_pcValid, fq_imData, fq_flush, fq_outReady,
      output fq_pcReady, fq_imAddr, fq_imRd, fq_outPc, fq_outInstr, fq_outValid
   );

   // PC register / instruction memory / decode side.
   modport slave (
`ifdef FQ_ALIGN_CHECK_EN
      input  fq_outAdel,
`endif
      output fq_pcIn, fq_pcValid, fq_imData, fq_flush, fq_outReady,
      input  fq_pcReady, fq_imAddr, fq_imRd, fq_outPc, fq_outInstr, fq_outValid
   );

endinterface

// File: rtl/fq_ring.sv
// DEPTH-entry ring buffer holding fetched (pc, instr) entries in arrival order.
// Latency: write visible at the head the cycle after wr_vld; head read is combinational.
// Backpressure: none internally; caller must never write when full. clr beats write and read.
module fq_ring
   import fq_pkg::*;
#(
   parameter int DEPTH = FQ_DEPTH_DEF
) (
   input  logic                     fq_clk,
   input  logic                     fq_reset_n,
   input  logic                     clr,
   input  logic                     wr_vld,
   input  fq_entry_t                wr_dat,
   input  logic                     rd_rdy,
   output logic                     rd_vld,
   output fq_entry_t                rd_dat,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   fq_entry_t       mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   count_q;
   logic            do_rd;

   assign rd_vld = (count_q != '0);
   assign do_rd  = rd_rdy && rd_vld;
   assign rd_dat = mem[rd_ptr];
   assign count  = count_q;

   // Pointers wrap naturally (DEPTH is a power of two); count holds on simultaneous write+read.
   always_ff @(posedge fq_clk) begin
      if (!fq_reset_n || clr) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (wr_vld) wr_ptr <= wr_ptr + PW'(1);
         if (do_rd)  rd_ptr <= rd_ptr + PW'(1);
         case ({wr_vld, do_rd})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Entry storage; contents are meaningless unless counted, so no reset needed.
   always_ff @(posedge fq_clk) begin
      if (wr_vld) mem[wr_ptr] <= wr_dat;
   end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues IM reads for accepted PCs and queues (pc, instr) for decode.
// Latency: accept in cycle N -> head valid in N+2; one accept per cycle sustained.
// Backpressure: pcReady drops when queued + in-flight reaches DEPTH or on flush. Option: FQ_ALIGN_CHECK_EN.
module fetch_queue
   import fq_pkg::*;
#(
   parameter int DEPTH = FQ_DEPTH_DEF
) (
   input  logic          fq_clk,
   input  logic          fq_reset_n,
   fetch_queue_if.master fq
);

   localparam int             CW        = $clog2(DEPTH) + 1;
   localparam logic [CW:0]    DEPTH_OCC = (CW+1)'(DEPTH);

   logic [CW-1:0] ring_count;
   logic          ring_vld;
   fq_entry_t     ring_head;
   fq_entry_t     wr_entry;
   logic [CW:0]   occupancy;
   logic          pc_ready;
   logic          accept;
   logic          fetch;
   logic          pop;
   logic          inflight_vld;
   logic [31:0]   inflight_pc;
   logic [31:0]   im_addr_q;
`ifdef FQ_ALIGN_CHECK_EN
   logic          pc_misal;
   logic          inflight_adel;
`endif

   // Ready looks only at registered occupancy and flush so it never depends on pcValid.
   assign occupancy = {1'b0, ring_count} + {{CW{1'b0}}, inflight_vld};
   assign pc_ready  = !fq.fq_flush && (occupancy < DEPTH_OCC);
   assign accept    = fq.fq_pcValid && pc_ready;

   // Reset cycles never strobe memory; misaligned PCs are queued but not fetched.
`ifdef FQ_ALIGN_CHECK_EN
   assign pc_misal  = fq_misaligned(fq.fq_pcIn);
   assign fetch     = accept && fq_reset_n && !pc_misal;
`else
   assign fetch     = accept && fq_reset_n;
`endif

   assign fq.fq_pcReady = pc_ready;
   assign fq.fq_imRd    = fetch;
   assign fq.fq_imAddr  = fetch ? fq.fq_pcIn : im_addr_q;

   // Remember the last driven IM address so it holds while no read is issued.
   always_ff @(posedge fq_clk) begin
      if (!fq_reset_n)  im_addr_q <= FQ_RESET_ADDR;
      else if (fetch)   im_addr_q <= fq.fq_pcIn;
   end

   // In-flight flag: cleared by reset or flush so the following response is dropped.
   always_ff @(posedge fq_clk) begin
      if (!fq_reset_n || fq.fq_flush) inflight_vld <= 1'b0;
      else                            inflight_vld <= accept;
   end

   // In-flight PC (and alignment flag) captured on accept.
   always_ff @(posedge fq_clk) begin
      if (accept) begin
         inflight_pc   <= fq.fq_pcIn;
`ifdef FQ_ALIGN_CHECK_EN
         inflight_adel <= pc_misal;
`endif
      end
   end

   // Build the tail entry from the latched PC and this cycle's IM data.
   always_comb begin
      wr_entry       = '0;
      wr_entry.pc    = inflight_pc;
      wr_entry.instr = fq.fq_imData;
`ifdef FQ_ALIGN_CHECK_EN
      wr_entry.adel  = inflight_adel;
      if (inflight_adel) wr_entry.instr = '0;
`endif
   end

   assign pop = ring_vld && fq.fq_outReady;

   fq_ring #(
      .DEPTH      (DEPTH)
   ) u_ring (
      .fq_clk     (fq_clk),
      .fq_reset_n (fq_reset_n),
      .clr        (fq.fq_flush),
      .wr_vld     (inflight_vld),
      .wr_dat     (wr_entry),
      .rd_rdy     (pop),
      .rd_vld     (ring_vld),
      .rd_dat     (ring_head),
      .count      (ring_count)
   );

   // Head outputs read as zero whenever the queue is empty.
   assign fq.fq_outValid = ring_vld;
   assign fq.fq_outPc    = ring_vld ? ring_head.pc    : '0;
   assign fq.fq_outInstr = ring_vld ? ring_head.instr : '0;
`ifdef FQ_ALIGN_CHECK_EN
   assign fq.fq_outAdel  = ring_vld && ring_head.adel;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=4) with a one-cycle instruction-memory model.
// Latency: n/a.
// Backpressure: exercised through outReady/pcReady sequences below.
module tb_fetch_queue;

   logic fq_clk = 1'b0;
   logic fq_reset_n;

   fetch_queue_if fq_if ();

   fetch_queue #(
      .DEPTH      (4)
   ) dut (
      .fq_clk     (fq_clk),
      .fq_reset_n (fq_reset_n),
      .fq         (fq_if)
   );

   always #5 fq_clk = ~fq_clk;

   int          checks = 0;
   int          errors = 0;
   logic        im_rd_q;
   logic [31:0] im_addr_q;
   logic [31:0] exp_q [8];
   int          acc;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Instruction memory contents.
   function automatic logic [31:0] im_word(input logic [31:0] a);
      case (a)
         32'h0000_3000: return 32'h0000_0011;
         32'h0000_3004: return 32'h0000_0022;
         32'h0000_3008: return 32'h0000_0033;
         32'h0000_300C: return 32'h0000_0044;
         default:       return {16'hC0DE, a[15:0]};
      endcase
   endfunction

   task automatic drive(input logic v, input logic [31:0] pc, input logic ordy, input logic fl);
      fq_if.fq_pcValid  = v;
      fq_if.fq_pcIn     = pc;
      fq_if.fq_outReady = ordy;
      fq_if.fq_flush    = fl;
      #1;
   endtask

   // Advance one clock; memory answers one cycle after a read strobe.
   task automatic step();
      im_rd_q   = fq_if.fq_imRd;
      im_addr_q = fq_if.fq_imAddr;
      @(posedge fq_clk);
      #1;
      fq_if.fq_imData = im_rd_q ? im_word(im_addr_q) : 32'hDEAD_DEAD;
   endtask

   initial begin
      fq_if.fq_imData = 32'hDEAD_DEAD;
      exp_q = '{32'h5004, 32'h5008, 32'h500C, 32'h6000,
                32'h6004, 32'h6008, 32'h600C, 32'h6010};

      // Reset, with a request presented: no read strobe while in reset.
      fq_reset_n = 1'b0;
      drive(1'b1, 32'h3000, 1'b0, 1'b0);
      chk("rst_imrd", {31'd0, fq_if.fq_imRd}, 32'd0);
      step();
      step();
      fq_reset_n = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      chk("rst_outvalid", {31'd0, fq_if.fq_outValid}, 32'd0);
      chk("rst_pcready",  {31'd0, fq_if.fq_pcReady},  32'd1);
      chk("rst_imrd2",    {31'd0, fq_if.fq_imRd},     32'd0);
      chk("rst_imaddr",   fq_if.fq_imAddr,            32'h3000);
      chk("rst_outpc",    fq_if.fq_outPc,             32'h0);
      chk("rst_outinstr", fq_if.fq_outInstr,          32'h0);

      // Back-to-back accepts, heads in cycles 2,3,4 without bubbles.
      drive(1'b1, 32'h3000, 1'b1, 1'b0);
      chk("b2b_imrd0",  {31'd0, fq_if.fq_imRd}, 32'd1);
      chk("b2b_imaddr0", fq_if.fq_imAddr, 32'h3000);
      step();
      drive(1'b1, 32'h3004, 1'b1, 1'b0);
      chk("b2b_vld1", {31'd0, fq_if.fq_outValid}, 32'd0);
      step();
      drive(1'b1, 32'h3008, 1'b1, 1'b0);
      chk("b2b_vld2",   {31'd0, fq_if.fq_outValid}, 32'd1);
      chk("b2b_pc2",    fq_if.fq_outPc,    32'h3000);
      chk("b2b_instr2", fq_if.fq_outInstr, 32'h11);
      step();
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      chk("b2b_pc3",    fq_if.fq_outPc,    32'h3004);
      chk("b2b_instr3", fq_if.fq_outInstr, 32'h22);
      chk("idle_imrd",  {31'd0, fq_if.fq_imRd}, 32'd0);
      chk("idle_imaddr", fq_if.fq_imAddr, 32'h3008);
      step();
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      chk("b2b_pc4",    fq_if.fq_outPc,    32'h3008);
      chk("b2b_instr4", fq_if.fq_outInstr, 32'h33);
      step();
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      chk("b2b_empty", {31'd0, fq_if.fq_outValid}, 32'd0);
      step();

      // Fill with decode stalled: exactly DEPTH accepts.
      acc = 0;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 32'h5000 + 32'(acc * 4), 1'b0, 1'b0);
         if (fq_if.fq_pcValid && fq_if.fq_pcReady) acc++;
         step();
      end
      chk("fill_accepts", 32'(acc), 32'd4);
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      chk("fill_pcready", {31'd0, fq_if.fq_pcReady}, 32'd0);
      chk("fill_headpc",  fq_if.fq_outPc,    32'h5000);
      chk("fill_instr",   fq_if.fq_outInstr, 32'hC0DE5000);
      step();

      // Ready returns after the first pop; streaming pop+accept keeps order across the wrap.
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, 32'h6000 + 32'(k * 4), 1'b1, 1'b0);
         chk($sformatf("wrap_pcready%0d", k), {31'd0, fq_if.fq_pcReady}, 32'd1);
         chk($sformatf("wrap_pc%0d", k),      fq_if.fq_outPc, exp_q[k]);
         chk($sformatf("wrap_instr%0d", k),   fq_if.fq_outInstr, {16'hC0DE, exp_q[k][15:0]});
         step();
      end
      for (int k = 0; k < 6; k++) begin
         drive(1'b0, 32'h0, 1'b1, 1'b0);
         step();
      end
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      chk("drain_empty",  {31'd0, fq_if.fq_outValid}, 32'd0);
      chk("drain_imaddr", fq_if.fq_imAddr, 32'h601C);

      // Flush with 3 queued + 1 in flight (0x300C -> 0x44), pop coinciding.
      drive(1'b1, 32'h7000, 1'b0, 1'b0); step();
      drive(1'b1, 32'h7004, 1'b0, 1'b0); step();
      drive(1'b1, 32'h7008, 1'b0, 1'b0); step();
      drive(1'b1, 32'h300C, 1'b0, 1'b0);
      chk("fl_pre_ready", {31'd0, fq_if.fq_pcReady}, 32'd1);
      step();
      drive(1'b1, 32'h8000, 1'b1, 1'b1);
      chk("fl_pcready", {31'd0, fq_if.fq_pcReady}, 32'd0);
      chk("fl_imrd",    {31'd0, fq_if.fq_imRd},    32'd0);
      chk("fl_data44",  fq_if.fq_imData,           32'h44);
      step();
      drive(1'b1, 32'h4000, 1'b1, 1'b0);
      chk("fl_outvalid", {31'd0, fq_if.fq_outValid}, 32'd0);
      chk("fl_ready",    {31'd0, fq_if.fq_pcReady},  32'd1);
      step();
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      chk("fl_gap", {31'd0, fq_if.fq_outValid}, 32'd0);
      step();
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      chk("fl_sole_vld",   {31'd0, fq_if.fq_outValid}, 32'd1);
      chk("fl_sole_pc",    fq_if.fq_outPc,    32'h4000);
      chk("fl_sole_instr", fq_if.fq_outInstr, 32'hC0DE4000);
      step();
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      chk("fl_after", {31'd0, fq_if.fq_outValid}, 32'd0);
      step();

      // Mid-stream reset one cycle after an accept.
      drive(1'b1, 32'h9000, 1'b1, 1'b0);
      chk("mr_imrd0", {31'd0, fq_if.fq_imRd}, 32'd1);
      step();
      fq_reset_n = 1'b0;
      drive(1'b1, 32'h9004, 1'b1, 1'b0);
      chk("mr_rst_imrd", {31'd0, fq_if.fq_imRd}, 32'd0);
      step();
      fq_reset_n = 1'b1;
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      chk("mr_outvalid", {31'd0, fq_if.fq_outValid}, 32'd0);
      chk("mr_pcready",  {31'd0, fq_if.fq_pcReady},  32'd1);
      chk("mr_imaddr",   fq_if.fq_imAddr,            32'h3000);
      step();
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      chk("mr_late1", {31'd0, fq_if.fq_outValid}, 32'd0);
      step();
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      chk("mr_late2", {31'd0, fq_if.fq_outValid}, 32'd0);
      step();

`ifdef FQ_ALIGN_CHECK_EN
      // Misaligned fetch is queued with adel set and no memory read.
      drive(1'b1, 32'h3002, 1'b1, 1'b0);
      chk("al_imrd0",   {31'd0, fq_if.fq_imRd}, 32'd0);
      chk("al_imaddr0", fq_if.fq_imAddr, 32'h3000);
      step();
      drive(1'b1, 32'h3004, 1'b1, 1'b0);
      chk("al_imrd1",   {31'd0, fq_if.fq_imRd}, 32'd1);
      chk("al_imaddr1", fq_if.fq_imAddr, 32'h3004);
      step();
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      chk("al_pc0",    fq_if.fq_outPc,    32'h3002);
      chk("al_adel0",  {31'd0, fq_if.fq_outAdel}, 32'd1);
      chk("al_instr0", fq_if.fq_outInstr, 32'h0);
      step();
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      chk("al_pc1",    fq_if.fq_outPc,    32'h3004);
      chk("al_adel1",  {31'd0, fq_if.fq_outAdel}, 32'd0);
      chk("al_instr1", fq_if.fq_outInstr, 32'h22);
      step();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
